core_fetch_unit: RTL

// - Parametrised instruction-fetch front end for the next-generation hmc-6502 core.
// - After reset, reads the reset vector (low byte, then high byte) and loads the fetch pointer from it.
// - Then streams sequential bytes from memory into a DEPTH-entry prefetch queue; control pops bytes one at a time.
// - Sits between the memory bus and the core's control/datapath; handles redirect (branch/jump) flush and razor stall.

---
 rtl/core_fetch_pkg.sv | 15 +
 rtl/core_fetch_unit_if.sv | 30 +++
 rtl/core_fetch_unit_fifo.sv | 43 ++++
 rtl/core_fetch_unit.sv | 112 +++++++++++
 4 files changed

// File: rtl/core_fetch_pkg.sv
// Shared types and default sizing for the hmc-6502 instruction-fetch front end.
package core_fetch_pkg;

  typedef enum logic [1:0] {
    VEC_LO = 2'd0,
    VEC_HI = 2'd1,
    STREAM = 2'd2
  } fetch_state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;
  localparam logic [15:0] DEF_RESET_VEC = 16'hFFFC;

endpackage

// File: rtl/core_fetch_unit_if.sv
// Memory-read and prefetch-queue signals of the fetch unit; master is the fetch unit.
// Handshake: a read completes in any cycle where read_en=1 and mem_ready=1 (no outstanding
// reads), and a byte is popped in any cycle where fetch_valid=1 and fetch_take=1.
interface core_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_address;
  logic              read_en;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_data;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_take;
  logic [CW-1:0]     queue_count;

  modport master (
    output mem_address, read_en, fetch_valid, fetch_data, fetch_pc, queue_count,
    input  mem_ready, mem_data, fetch_take
  );

  modport slave (
    input  mem_address, read_en, fetch_valid, fetch_data, fetch_pc, queue_count,
    output mem_ready, mem_data, fetch_take
  );
endinterface

// File: rtl/core_fetch_unit_fifo.sv
// Prefetch queue: circular buffer holding {byte, fetch address} pairs with flush.
module fetch_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 push_data,
  output logic [W-1:0]                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // The caller never pushes when full or pops when empty.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

// File: rtl/core_fetch_unit.sv
// Fetch front end: reads the reset vector, then streams sequential bytes into the prefetch queue.
module core_fetch_unit
  import core_fetch_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                DEPTH     = DEF_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC)
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  core_fetch_unit_if.master bus,
  output fetch_state_t      state_dbg
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_t      state, state_next;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] vec_lo;
  logic [CW-1:0]     count;
  logic [DATA_W+ADDR_W-1:0] head;
  logic              req, ack, push, pop, flush, head_valid;
  logic [ADDR_W-1:0] addr;

  // req already excludes reset/stall/redirect, so ack is a real completion.
  assign ack        = req && bus.mem_ready;
  assign push       = (state == STREAM) && ack;
  assign head_valid = !reset && !stall && (count != '0);
  assign pop        = head_valid && bus.fetch_take && !redirect;
  assign flush      = redirect && !stall;

  always_ff @(posedge ph1) begin
    if (reset)       state <= VEC_LO;
    else if (!stall) state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = STREAM;
    end else begin
      case (state)
        VEC_LO:  if (ack) state_next = VEC_HI;
        VEC_HI:  if (ack) state_next = STREAM;
        default: state_next = state;
      endcase
    end
  end

  // Streaming requests look at the registered count, so a full queue being popped stays idle.
  always_comb begin
    req  = 1'b0;
    addr = RESET_VEC;
    case (state)
      VEC_LO: begin
        addr = RESET_VEC;
        req  = 1'b1;
      end
      VEC_HI: begin
        addr = RESET_VEC + ADDR_W'(1);
        req  = 1'b1;
      end
      STREAM: begin
        addr = ptr;
        req  = (count < FULL);
      end
      default: begin
        addr = RESET_VEC;
        req  = 1'b0;
      end
    endcase
    if (reset || stall || redirect) req = 1'b0;
  end

  always_ff @(posedge ph1) begin
    if (reset) begin
      ptr    <= '0;
      vec_lo <= '0;
    end else if (!stall) begin
      if (state == VEC_LO && ack) vec_lo <= bus.mem_data;
      if (redirect)                    ptr <= redirect_addr;
      else if (state == VEC_HI && ack) ptr <= ADDR_W'({bus.mem_data, vec_lo});
      else if (push)                   ptr <= ptr + 1'b1;
    end
  end

  fetch_fifo #(
    .W     (DATA_W + ADDR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (ph1),
    .rst       (reset),
    .flush     (flush),
    .push      (push),
    .pop       (pop),
    .push_data ({bus.mem_data, ptr}),
    .head      (head),
    .count     (count)
  );

  assign bus.mem_address = addr;
  assign bus.read_en     = req;
  assign bus.fetch_valid = head_valid;
  assign bus.fetch_data  = head[DATA_W+ADDR_W-1:ADDR_W];
  assign bus.fetch_pc    = head[ADDR_W-1:0];
  assign bus.queue_count = count;
  assign state_dbg       = state;
endmodule
